systolic_cmd_sequencer: RTL

- Initiator side of the systolic array's load/compute interface; sits between the RISC-V coprocessor command port and the systolic subsystem.
- Accepts one matrix-multiply command (weight matrix and data matrix), drives the weight-load then data-load sequence on PEmode/out_valid/din_data, waits for the completion flags, captures result and returns it on a valid/ready response port.
- Watchdog timeout and a cycle count per job.

---
 rtl/systolic_cmd_sequencer_if.sv | 35 +++
 rtl/systolic_cmd_sequencer.sv | 96 +++++++++
 2 files changed

// File: rtl/systolic_cmd_sequencer_if.sv
// Command, response and systolic-array signals of the job sequencer.
// master: the sequencer side; slave: the coprocessor/array environment side.
interface systolic_cmd_sequencer_if #(
   parameter int PE_ROW = 4,
   parameter int PE_COL = 4,
   parameter int DWIDTH = 8
);
   localparam int MW = PE_ROW * PE_COL * DWIDTH;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [MW-1:0] cmd_weight;
   logic [MW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [MW-1:0] rsp_result;
   logic          rsp_error;
   logic [15:0]   rsp_cycles;
   logic [MW-1:0] din_data;
   logic [1:0]    PEmode;
   logic          out_valid;
   logic [MW-1:0] result;
   logic          load_is_finish;
   logic          final_is_finish;

   modport master (
      input  cmd_valid, cmd_weight, cmd_data, rsp_ready, result, load_is_finish, final_is_finish,
      output cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_cycles, din_data, PEmode, out_valid
   );

   modport slave (
      output cmd_valid, cmd_weight, cmd_data, rsp_ready, result, load_is_finish, final_is_finish,
      input  cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_cycles, din_data, PEmode, out_valid
   );
endinterface

// File: rtl/systolic_cmd_sequencer.sv
// Runs one matrix-multiply job through the systolic array: weight load, data load, wait for
// completion, then return the captured result (or a timeout error) on the response port.
module systolic_cmd_sequencer #(
   parameter int PE_ROW  = 4,
   parameter int PE_COL  = 4,
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = 1024
) (
   input logic                      clk,
   input logic                      rst_n,
   systolic_cmd_sequencer_if.master sif
);
   localparam int MW = PE_ROW * PE_COL * DWIDTH;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WLOAD, WWAIT, DLOAD, CALC, RESP} state_t;

   state_t        state, state_nxt;
   logic [MW-1:0] data_q;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]   cyc_cnt, cyc_cur;
   logic          fin_prev, fin_rise, tmo_hit, cmd_fire, rsp_fire;

   always_comb begin
      state_nxt = state;
      cmd_fire  = sif.cmd_valid && sif.cmd_ready;
      rsp_fire  = sif.rsp_valid && sif.rsp_ready;
      fin_rise  = sif.final_is_finish && !fin_prev;
      tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
      // cyc_cnt holds completed CALC cycles; cyc_cur includes the current one.
      cyc_cur   = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
      case (state)
         IDLE:    if (cmd_fire) state_nxt = WLOAD;
         WLOAD:   state_nxt = WWAIT;
         WWAIT:   if (sif.load_is_finish) state_nxt = DLOAD;
                  else if (tmo_hit)       state_nxt = RESP;
         DLOAD:   state_nxt = CALC;
         CALC:    if (fin_rise || tmo_hit) state_nxt = RESP;
         RESP:    if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         data_q         <= '0;
         tmo_cnt        <= '0;
         cyc_cnt        <= '0;
         fin_prev       <= 1'b0;
         sif.cmd_ready  <= 1'b1;
         sif.rsp_valid  <= 1'b0;
         sif.rsp_error  <= 1'b0;
         sif.rsp_result <= '0;
         sif.rsp_cycles <= '0;
         sif.din_data   <= '0;
         sif.PEmode     <= 2'b00;
         sif.out_valid  <= 1'b0;
      end else begin
         state         <= state_nxt;
         fin_prev      <= sif.final_is_finish;
         sif.cmd_ready <= (state_nxt == IDLE);
         sif.rsp_valid <= (state_nxt == RESP);
         sif.out_valid <= (state_nxt != IDLE) && (state_nxt != RESP);
         case (state_nxt)
            WLOAD:       sif.PEmode <= 2'b01;
            DLOAD, CALC: sif.PEmode <= 2'b11;
            default:     sif.PEmode <= 2'b00;
         endcase

         // din_data doubles as the weight register from acceptance until DLOAD.
         if (cmd_fire) begin
            sif.din_data <= sif.cmd_weight;
            data_q       <= sif.cmd_data;
         end else if (state_nxt == DLOAD) begin
            sif.din_data <= data_q;
         end

         if ((state_nxt == state) && ((state == WWAIT) || (state == CALC)))
            tmo_cnt <= tmo_cnt + TW'(1);
         else
            tmo_cnt <= '0;

         if (cmd_fire || (state == DLOAD))
            cyc_cnt <= '0;
         else if (state == CALC)
            cyc_cnt <= cyc_cur;

         if ((state_nxt == RESP) && (state != RESP)) begin
            sif.rsp_error  <= !((state == CALC) && fin_rise);
            sif.rsp_result <= ((state == CALC) && fin_rise) ? sif.result : '0;
            sif.rsp_cycles <= (state == CALC) ? cyc_cur : cyc_cnt;
         end
      end
   end
endmodule
